fan_frame_sequencer: RTL and testbench

Sequences multi-frame animations on the 16-LED POV fan.
- Owns the angular position counter: syncs the fanclk step pulse, counts deg 360..1 and detects each revolution wrap.
- Chooses which of NUM_FRAMES pattern generators drives the LEDs. Generators decode deg combinationally.
- Frame changes happen only at the revolution boundary, so the image never tears mid-sweep.

---
 rtl/fan_frame_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_fan_frame_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fan_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fan_frame_sequencer
//
// Sequences multi-frame animations on a 16-LED POV fan. The block owns the
// angular position counter. That counter is stepped by the asynchronous fanclk
// and counts deg from DEG_MAX down to 1, then reloads. The block also picks
// which of NUM_FRAMES external pattern generators drives the LEDs. Frame
// changes only take effect on a revolution wrap, so an image never tears
// mid-sweep.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   fanclk     fan step input, asynchronous; one rising edge per degree step
//   en         animation enable (level)
//   hold       freeze the current frame (sampled at wrap only)
//   bounce     1 = ping-pong frame order, 0 = loop order
//   frame_leds generator outputs; frame k occupies bits [16k+15:16k]
//   deg        current angular position, DEG_MAX..1
//   frame_sel  index of the displayed frame
//   rev_tick   one-cycle pulse in the cycle deg reloads to DEG_MAX
//   led        LED drive (combinational from frame_leds)
// -----------------------------------------------------------------------------
module fan_frame_sequencer #(
    parameter int NUM_FRAMES     = 5,
    parameter int DEG_MAX        = 360,
    parameter int REVS_PER_FRAME = 8,
    parameter int FRAME_W        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fanclk,
    input  logic                     en,
    input  logic                     hold,
    input  logic                     bounce,
    input  logic [NUM_FRAMES*16-1:0] frame_leds,
    output logic [8:0]               deg,
    output logic [FRAME_W-1:0]       frame_sel,
    output logic                     rev_tick,
    output logic [15:0]              led
);

    localparam int REV_W = (REVS_PER_FRAME > 1) ? $clog2(REVS_PER_FRAME) : 1;
    localparam logic [8:0]         DEG_TOP    = 9'(DEG_MAX);
    localparam logic [REV_W-1:0]   REV_LAST   = REV_W'(REVS_PER_FRAME - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, PLAY} state_t;

    // fanclk synchronizer (s1, s2) plus the edge-detect history flop (s3)
    logic fan_s1_q, fan_s2_q, fan_s3_q;
    logic step;
    logic wrap;

    logic [8:0]         deg_q, deg_d;
    logic               rev_tick_q;
    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
    logic               dir_down_q, dir_down_d;   // 0 = counting up

    // Frame table padded to a power of two so any frame_sel value indexes safely
    logic [15:0] frame_tab [2**FRAME_W];

    for (genvar k = 0; k < 2**FRAME_W; k++) begin : g_tab
        if (k < NUM_FRAMES) begin : g_used
            assign frame_tab[k] = frame_leds[16*k +: 16];
        end else begin : g_pad
            assign frame_tab[k] = 16'h0000;
        end
    end

    // A fanclk that is held high produces a single step: only the 0->1 edge
    // of the synchronized signal counts.
    assign step = fan_s2_q & ~fan_s3_q;
    assign wrap = step && (deg_q == 9'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fan_s1_q <= 1'b0;
            fan_s2_q <= 1'b0;
            fan_s3_q <= 1'b0;
        end else begin
            fan_s1_q <= fanclk;
            fan_s2_q <= fan_s1_q;
            fan_s3_q <= fan_s2_q;
        end
    end

    // Position counter runs in every FSM state.
    always_comb begin
        deg_d = deg_q;
        if (step) begin
            deg_d = (deg_q == 9'd1) ? DEG_TOP : deg_q - 9'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deg_q      <= DEG_TOP;
            rev_tick_q <= 1'b0;
        end else begin
            deg_q      <= deg_d;
            rev_tick_q <= wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            rev_cnt_q  <= '0;
            dir_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            rev_cnt_q  <= rev_cnt_d;
            dir_down_q <= dir_down_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        rev_cnt_d  = rev_cnt_q;
        dir_down_d = dir_down_q;

        if (!en) begin
            // Dropping en wins over a simultaneous wrap: no advance happens.
            state_d    = IDLE;
            frame_d    = '0;
            rev_cnt_d  = '0;
            dir_down_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    frame_d    = '0;
                    rev_cnt_d  = '0;
                    dir_down_d = 1'b0;
                    state_d    = ARM;
                end
                ARM: begin
                    // Start playing at the top of a revolution.
                    if (wrap) begin
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (wrap && !hold) begin
                        if (rev_cnt_q != REV_LAST) begin
                            rev_cnt_d = rev_cnt_q + REV_W'(1);
                        end else begin
                            rev_cnt_d = '0;
                            if (NUM_FRAMES == 1) begin
                                frame_d    = '0;
                                dir_down_d = 1'b0;
                            end else if (!bounce) begin
                                dir_down_d = 1'b0;
                                frame_d    = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_ONE;
                            end else if (!dir_down_q) begin
                                if (frame_q == FRAME_LAST) begin
                                    frame_d    = frame_q - FRAME_ONE;
                                    dir_down_d = 1'b1;
                                end else begin
                                    frame_d = frame_q + FRAME_ONE;
                                end
                            end else begin
                                if (frame_q == '0) begin
                                    frame_d    = FRAME_ONE;
                                    dir_down_d = 1'b0;
                                end else begin
                                    frame_d = frame_q - FRAME_ONE;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        led = 16'h0000;
        if (state_q == PLAY) begin
            led = frame_tab[frame_q];
        end
    end

    assign deg       = deg_q;
    assign frame_sel = frame_q;
    assign rev_tick  = rev_tick_q;

endmodule

// File: tb/tb_fan_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for fan_frame_sequencer. A short revolution (DEG steps)
// keeps the many multi-wrap frame sequences within a small cycle count. Frame
// k drives the pattern 1<<k, so led identifies the displayed frame directly.
// -----------------------------------------------------------------------------
module tb_fan_frame_sequencer;

    localparam int NF  = 5;
    localparam int DEG = 24;
    localparam int RPF = 8;
    localparam int FW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           fanclk;
    logic           en;
    logic           hold;
    logic           bounce;
    logic [NF*16-1:0] frame_leds;
    logic [8:0]     deg;
    logic [FW-1:0]  frame_sel;
    logic           rev_tick;
    logic [15:0]    led;

    int total = 0;
    int bad   = 0;
    int rt_cnt = 0;
    int lat_bad = 0;
    bit wrapped;
    logic [FW-1:0] fs_pre, fs_post;
    logic [15:0]   led_pre;
    logic [8:0]    dsave;
    int prev;
    int bseq [8] = '{2, 3, 4, 3, 2, 1, 0, 1};

    fan_frame_sequencer #(
        .NUM_FRAMES(NF), .DEG_MAX(DEG), .REVS_PER_FRAME(RPF), .FRAME_W(FW)
    ) u_dut (
        .clk(clk), .rst(rst), .fanclk(fanclk), .en(en), .hold(hold),
        .bounce(bounce), .frame_leds(frame_leds), .deg(deg),
        .frame_sel(frame_sel), .rev_tick(rev_tick), .led(led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One fanclk pulse, 4 clk long; deg must move exactly at the 3rd edge.
    task automatic step();
        logic [8:0] d0, dexp;
        logic [FW-1:0] fs_t;
        logic [15:0]   led_t;
        d0 = deg;
        dexp = (d0 == 9'd1) ? 9'(DEG) : d0 - 9'd1;
        wrapped = 1'b0;
        fanclk = 1'b1;
        tick();
        if (deg !== d0 || rev_tick !== 1'b0) lat_bad++;
        fanclk = 1'b0;
        tick();
        if (deg !== d0 || rev_tick !== 1'b0) lat_bad++;
        fs_t = frame_sel;
        led_t = led;
        tick();
        if (deg !== dexp || rev_tick !== (d0 == 9'd1)) lat_bad++;
        if (rev_tick === 1'b1) begin
            wrapped = 1'b1;
            rt_cnt++;
            fs_pre  = fs_t;
            led_pre = led_t;
            fs_post = frame_sel;
        end
        tick();
        if (deg !== dexp || rev_tick !== 1'b0) lat_bad++;
    endtask

    task automatic to_wrap();
        int n;
        n = 0;
        wrapped = 1'b0;
        while (!wrapped && n < DEG + 1) begin
            step();
            n++;
        end
        if (!wrapped) chk("wrap_timeout", 32'(wrapped), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        fanclk = 1'b0;
        en = 1'b0;
        hold = 1'b0;
        bounce = 1'b0;
        for (int k = 0; k < NF; k++) frame_leds[16*k +: 16] = 16'(1 << k);

        // Reset state
        repeat (3) tick();
        chk("rst_deg", 32'(deg), DEG);
        chk("rst_fs", 32'(frame_sel), 0);
        chk("rst_tick", 32'(rev_tick), 0);
        chk("rst_led", 32'(led), 0);
        rst = 1'b0;
        tick();

        // 1: one full revolution of single pulses
        step();
        chk("t1_first", 32'(deg), DEG - 1);
        repeat (DEG - 2) step();
        chk("t1_last", 32'(deg), 1);
        chk("t1_notick", rt_cnt, 0);
        step();
        chk("t1_reload", 32'(deg), DEG);
        chk("t1_tickcnt", rt_cnt, 1);
        chk("t1_timing", lat_bad, 0);

        // 2: fanclk held high gives a single step
        dsave = deg;
        fanclk = 1'b1;
        repeat (20) tick();
        fanclk = 1'b0;
        repeat (4) tick();
        chk("t2_onestep", 32'(deg), 32'(dsave) - 1);

        // 3: enable mid-revolution, display starts at the wrap
        repeat (DEG / 2 - 1) step();
        chk("t3_middeg", 32'(deg), DEG / 2);
        en = 1'b1;
        tick();
        tick();
        chk("t3_arm_led", 32'(led), 0);
        to_wrap();
        chk("t3_led_prewrap", 32'(led_pre), 0);
        chk("t3_play_led", 32'(led), 16'h0001);
        chk("t3_play_deg", 32'(deg), DEG);
        repeat (RPF - 1) to_wrap();
        chk("t3_hold7", 32'(frame_sel), 0);
        to_wrap();
        chk("t3_fs_pre", 32'(fs_pre), 0);
        chk("t3_fs_post", 32'(fs_post), 1);
        chk("t3_led2", 32'(led), 16'h0002);
        chk("t3_deg_top", 32'(deg), DEG);

        // 4: loop order, then ping-pong
        for (int w = 1; w <= 5 * RPF; w++) begin
            to_wrap();
            if (w % RPF == 0) begin
                chk("t4_loop_adv", 32'(frame_sel), (1 + w / RPF) % NF);
                chk("t4_loop_led", 32'(led), 1 << ((1 + w / RPF) % NF));
            end else if (w % RPF == RPF - 1) begin
                chk("t4_loop_hold", 32'(frame_sel), (1 + w / RPF) % NF);
            end
        end
        bounce = 1'b1;
        prev = 1;
        for (int a = 0; a < 8; a++) begin
            repeat (RPF - 1) to_wrap();
            chk("t4_bnc_hold", 32'(frame_sel), prev);
            to_wrap();
            chk("t4_bnc_adv", 32'(frame_sel), bseq[a]);
            prev = bseq[a];
        end

        // 5: hold freezes the frame for 3 wraps
        repeat (4) to_wrap();
        hold = 1'b1;
        repeat (3) to_wrap();
        chk("t5_held", 32'(frame_sel), 1);
        hold = 1'b0;
        repeat (3) to_wrap();
        chk("t5_late", 32'(frame_sel), 1);
        to_wrap();
        chk("t5_adv", 32'(frame_sel), 2);

        // 5b: en dropped exactly on the wrap that would advance
        repeat (RPF - 1) to_wrap();
        chk("t5_pre_drop", 32'(frame_sel), 2);
        repeat (DEG - 1) step();
        chk("t5_deg1", 32'(deg), 1);
        fanclk = 1'b1;
        tick();
        fanclk = 1'b0;
        tick();
        en = 1'b0;
        tick();
        chk("t5_drop_deg", 32'(deg), DEG);
        chk("t5_drop_tick", 32'(rev_tick), 1);
        chk("t5_drop_fs", 32'(frame_sel), 0);
        chk("t5_drop_led", 32'(led), 0);
        tick();

        // 6: asynchronous reset mid-PLAY
        en = 1'b1;
        tick();
        to_wrap();
        repeat (RPF) to_wrap();
        chk("t6_fs", 32'(frame_sel), 1);
        repeat (5) step();
        chk("t6_deg", 32'(deg), DEG - 5);
        chk("t6_led", 32'(led), 16'h0002);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_deg", 32'(deg), DEG);
        chk("t6_rst_fs", 32'(frame_sel), 0);
        chk("t6_rst_led", 32'(led), 0);
        chk("t6_rst_tick", 32'(rev_tick), 0);
        tick();
        rst = 1'b0;
        tick();

        chk("step_timing", lat_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
